rr_arb_4_1: RTL and testbench

// Round-robin 4:1 stream arbiter that feeds the 4:1 index-select mux stage.
// It takes four valid/ready input channels, picks one per cycle in fair

---
 rtl/rr_arb_4_1.sv | 70 +++++++
 tb/tb_rr_arb_4_1.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rr_arb_4_1.sv
// Round-robin 4:1 stream arbiter with a registered output slot.
// Each word leaves tagged with the index of the channel that supplied it.
module rr_arb_4_1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic [3:0]   in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel,
    input  logic         out_ready
);

    logic [3:0][W-1:0] data_arr;
    logic [1:0]        ptr;
    logic [1:0]        grant;
    logic              grant_vld;
    logic              found;
    logic [1:0]        idx;
    logic              free;

    assign data_arr = {in_data3, in_data2, in_data1, in_data0};
    assign free     = ~out_valid | out_ready;

    // The first valid channel at or after ptr wins; the 2-bit index wraps.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && in_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        grant_vld = |in_valid;
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && free && grant_vld)
            in_ready = 4'b0001 << grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (free) begin
            if (grant_vld) begin
                out_valid <= 1'b1;
                out_data  <= data_arr[grant];
                out_sel   <= grant;
                ptr       <= grant + 2'd1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_4_1.sv
// Bench for rr_arb_4_1: directed scenarios followed by random traffic,
// all compared against a behavioural round-robin model.
module tb_rr_arb_4_1;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [W-1:0] din [4];
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    // behavioural model state
    int           m_ptr;
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    int           waits [4];
    logic [3:0]   exp_ready;
    logic [3:0]   hold;

    rr_arb_4_1 #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_data0(din[0]), .in_data1(din[1]), .in_data2(din[2]), .in_data3(din[3]),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++)
            if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_data = '0; m_sel = 0;
        for (int i = 0; i < 4; i++) waits[i] = 0;
    endtask

    // One clock: drive at negedge, check ready, then check registered outputs.
    task automatic step(input logic [3:0] v, input logic r);
        int g;
        bit fr;
        @(negedge clk);
        in_valid = v;
        out_ready = r;
        #1;
        fr = !m_valid || r;
        g = pick(v, m_ptr);
        exp_ready = (fr && g >= 0) ? 4'(1 << g) : 4'b0000;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        @(posedge clk);
        if (fr) begin
            if (g >= 0) begin
                check("fairness", 32'(waits[g] <= 3), 32'd1);
                for (int i = 0; i < 4; i++)
                    if (v[i] && i != g) waits[i]++;
                waits[g] = 0;
                m_valid = 1; m_data = din[g]; m_sel = g; m_ptr = (g + 1) % 4;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_sel", 32'(out_sel), 32'(m_sel));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        model_reset();
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // single channel
        din[2] = 4'hc;
        step(4'b0100, 1'b1);
        check("single_sel", 32'(out_sel), 32'd2);
        check("single_data", 32'(out_data), 32'hc);

        // all valid, pointer wraps
        din[0] = 4'ha; din[1] = 4'hb; din[2] = 4'hc; din[3] = 4'hd;
        repeat (8) step(4'b1111, 1'b1);

        // backpressure then accept with a same-edge reload
        repeat (3) step(4'b1111, 1'b0);
        step(4'b1111, 1'b1);

        // skip and rotate: land on channel 1, then offer 0 and 1
        step(4'b0010, 1'b1);
        step(4'b0011, 1'b1);
        check("skip_sel0", 32'(out_sel), 32'd0);
        step(4'b0010, 1'b1);
        check("skip_sel1", 32'(out_sel), 32'd1);

        // idle drain
        step(4'b0000, 1'b1);
        check("drain_sel", 32'(out_sel), 32'd1);
        step(4'b0100, 1'b1);
        check("drain_ptr", 32'(out_sel), 32'd2);

        // asynchronous reset mid-stream with out_valid high
        din[3] = 4'h5;
        step(4'b1000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_sel", 32'(out_sel), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step(4'b1111, 1'b1);
        check("post_rst_sel", 32'(out_sel), 32'd0);

        // random traffic; a raised valid is held until its handshake
        hold = '0;
        for (int n = 0; n < 400; n++) begin
            logic [3:0] v;
            v = hold | (4'($urandom) & 4'($urandom));
            for (int i = 0; i < 4; i++)
                if (v[i] && !hold[i]) din[i] = 4'($urandom);
            step(v, ($urandom_range(0, 3) != 0));
            hold = v & ~exp_ready;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
